// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared constants and state encoding for the MAC scheduler
package mac_pkg;

  localparam int LANE_WIDTH = 8;
  localparam int ACC_WIDTH  = 20;
  localparam int ATTR_WIDTH = 24;
  localparam int NUM_LANES  = ATTR_WIDTH / LANE_WIDTH;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MAC    = 2'd1,
    RESULT = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant starting after the pointer
module rr_arbiter #(
  parameter  int NUM_REQ  = 4,
  localparam int ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic [NUM_REQ-1:0]  grant,
  output logic [ID_WIDTH-1:0] idx,
  output logic                any
);

  int cand;

  // Scan offsets from farthest to nearest so the nearest valid requester after ptr wins
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = (int'(ptr) + k) % NUM_REQ;
      if (req[cand]) begin
        grant = NUM_REQ'(1) << cand;
        idx   = ID_WIDTH'(cand);
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mac_rr_scheduler.sv
// rtl/mac_rr_scheduler.sv - round-robin shared byte-serial multiply-accumulate engine
module mac_rr_scheduler
  import mac_pkg::*;
#(
  parameter  int NUM_REQ         = 4,
  parameter  int ATTR_WIDTH      = 24,
  parameter  int RAM1_DATA_WIDTH = 24,
  parameter  int LANE_WIDTH      = mac_pkg::LANE_WIDTH,
  parameter  int ACC_WIDTH       = mac_pkg::ACC_WIDTH,
  localparam int NUM_LANES       = ATTR_WIDTH / LANE_WIDTH,
  localparam int ID_WIDTH        = $clog2(NUM_REQ)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_REQ-1:0]                   req_valid,
  output logic [NUM_REQ-1:0]                   req_ready,
  input  logic [NUM_REQ*ATTR_WIDTH-1:0]        req_attr,
  input  logic [NUM_REQ*RAM1_DATA_WIDTH-1:0]   req_coeff,
  output logic                                 res_valid,
  input  logic                                 res_ready,
  output logic [ACC_WIDTH-1:0]                 res_acc,
  output logic [ID_WIDTH-1:0]                  res_id,
  output logic                                 busy
);

  localparam int LANE_CW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  state_t                     state_q, state_d;
  logic [NUM_REQ-1:0]         grant;
  logic [ID_WIDTH-1:0]        grant_idx;
  logic                       grant_any;
  logic [ID_WIDTH-1:0]        rr_ptr_q;
  logic [ID_WIDTH-1:0]        id_q;
  logic [ATTR_WIDTH-1:0]      attr_q;
  logic [RAM1_DATA_WIDTH-1:0] coeff_q;
  logic [ACC_WIDTH-1:0]       acc_q;
  logic [ACC_WIDTH-1:0]       acc_sum;
  logic [ACC_WIDTH-1:0]       res_acc_q;
  logic [ID_WIDTH-1:0]        res_id_q;
  logic [LANE_CW-1:0]         lane_q;
  logic [2*LANE_WIDTH-1:0]    prod;
  logic                       accept;
  logic                       last_lane;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .grant (grant),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  // Operands are shifted left each lane, so the current lane is always the top byte
  assign prod      = (2*LANE_WIDTH)'(attr_q[ATTR_WIDTH-1 -: LANE_WIDTH])
                   * (2*LANE_WIDTH)'(coeff_q[RAM1_DATA_WIDTH-1 -: LANE_WIDTH]);
  assign acc_sum   = acc_q + ACC_WIDTH'(prod);
  assign last_lane = (lane_q == LANE_CW'(NUM_LANES - 1));

  assign res_valid = (state_q == RESULT);
  assign busy      = (state_q != IDLE);
  assign res_acc   = res_acc_q;
  assign res_id    = res_id_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and grant decode; grants only issue while idle
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_any) begin
          req_ready = grant;
          accept    = 1'b1;
          state_d   = MAC;
        end
      end
      MAC:     if (last_lane) state_d = RESULT;
      RESULT:  if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand latch, lane sequencing, accumulation and result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q  <= ID_WIDTH'(NUM_REQ - 1);
      id_q      <= '0;
      attr_q    <= '0;
      coeff_q   <= '0;
      acc_q     <= '0;
      lane_q    <= '0;
      res_acc_q <= '0;
      res_id_q  <= '0;
    end else if (accept) begin
      attr_q   <= req_attr[grant_idx*ATTR_WIDTH +: ATTR_WIDTH];
      coeff_q  <= req_coeff[grant_idx*RAM1_DATA_WIDTH +: RAM1_DATA_WIDTH];
      id_q     <= grant_idx;
      rr_ptr_q <= grant_idx;
      acc_q    <= '0;
      lane_q   <= '0;
    end else if (state_q == MAC) begin
      acc_q   <= acc_sum;
      attr_q  <= attr_q << LANE_WIDTH;
      coeff_q <= coeff_q << LANE_WIDTH;
      lane_q  <= lane_q + 1'b1;
      if (last_lane) begin
        res_acc_q <= acc_sum;
        res_id_q  <= id_q;
      end
    end
  end

endmodule

// File: tb/tb_mac_rr_scheduler.sv
// tb/tb_mac_rr_scheduler.sv - scoreboard bench for the round-robin MAC scheduler
module tb_mac_rr_scheduler;

  localparam int N    = 4;
  localparam int AW   = 24;
  localparam int ACCW = 20;
  localparam int IDW  = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_attr;
  logic [N*AW-1:0] req_coeff;
  logic            res_valid;
  logic            res_ready;
  logic [ACCW-1:0] res_acc;
  logic [IDW-1:0]  res_id;
  logic            busy;

  mac_rr_scheduler dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_attr  (req_attr),
    .req_coeff (req_coeff),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_acc   (res_acc),
    .res_id    (res_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              id;
    logic [ACCW-1:0] acc;
  } exp_t;

  int              checks   = 0;
  int              failures = 0;
  exp_t            exp_q[$];
  int              grant_log[$];
  int              grant_time[$];
  int              cyc = 0;
  logic            samp_rv;
  logic [ACCW-1:0] samp_acc;
  logic [IDW-1:0]  samp_id;
  logic [N-1:0]    samp_ready;

  function automatic logic [ACCW-1:0] dot(input logic [AW-1:0] a, input logic [AW-1:0] b);
    int s;
    s = 0;
    for (int l = 0; l < AW/8; l++) s += int'(a[l*8 +: 8]) * int'(b[l*8 +: 8]);
    return ACCW'(s);
  endfunction

  // One clock: sample just after the falling edge, score grants/results, advance to next falling edge
  task automatic tick();
    exp_t e;
    #1;
    samp_rv    = res_valid;
    samp_acc   = res_acc;
    samp_id    = res_id;
    samp_ready = req_ready;
    checks++;
    if ($countones(req_ready) > 1) begin
      failures++;
      $display("FAIL onehot_ready ready=%b required at most one bit", req_ready);
    end
    for (int i = 0; i < N; i++) begin
      if (req_ready[i] && req_valid[i]) begin
        e.id  = i;
        e.acc = dot(req_attr[i*AW +: AW], req_coeff[i*AW +: AW]);
        exp_q.push_back(e);
        grant_log.push_back(i);
        grant_time.push_back(cyc);
      end
    end
    if (res_valid && res_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_result id=%0d acc=0x%05h required no result", res_id, res_acc);
      end else begin
        e = exp_q.pop_front();
        if (res_id !== IDW'(e.id) || res_acc !== e.acc) begin
          failures++;
          $display("FAIL result id=%0d acc=0x%05h required id=%0d acc=0x%05h",
                   res_id, res_acc, e.id, e.acc);
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    res_ready = 1'b0;
    req_attr  = '0;
    req_coeff = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_result();
    samp_rv = 1'b0;
    for (int k = 0; k < 20 && !samp_rv; k++) tick();
    checks++;
    if (!samp_rv) begin
      failures++;
      $display("FAIL result_timeout res_valid=0 required 1 within 20 cycles");
    end
  endtask

  task automatic drain();
    res_ready = 1'b1;
    for (int k = 0; k < 40 && (busy || exp_q.size() != 0); k++) tick();
    checks++;
    if (busy !== 1'b0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain busy=%b pending=%0d required busy=0 pending=0", busy, exp_q.size());
    end
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    checks++;
    if (req_ready !== '0 || res_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl ready=%b rv=%b busy=%b required 0000 0 0", req_ready, res_valid, busy);
    end
    checks++;
    if (res_acc !== '0 || res_id !== '0) begin
      failures++;
      $display("FAIL reset_data acc=0x%05h id=%0d required 0 0", res_acc, res_id);
    end
    @(negedge clk);
  endtask

  task automatic test_single();
    int lat;
    apply_reset();
    res_ready = 1'b1;
    req_attr[1*AW +: AW]  = 24'h010203;
    req_coeff[1*AW +: AW] = 24'h040506;
    req_valid = 4'b0010;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      failures++;
      $display("FAIL single_grant ready=%b required 0010", req_ready);
    end
    tick();
    req_valid = '0;
    lat = 0;
    samp_rv = 1'b0;
    for (int k = 0; k < 20 && !samp_rv; k++) begin
      tick();
      lat++;
      if (k == 0) begin
        checks++;
        if (samp_ready !== '0) begin
          failures++;
          $display("FAIL single_ready_pulse ready=%b required 0000", samp_ready);
        end
      end
    end
    checks++;
    if (lat != 4) begin
      failures++;
      $display("FAIL single_latency cycles=%0d required 4", lat);
    end
    checks++;
    if (samp_acc !== 20'h00020 || samp_id !== 2'd1) begin
      failures++;
      $display("FAIL single_value acc=0x%05h id=%0d required 0x00020 1", samp_acc, samp_id);
    end
    drain();
  endtask

  task automatic test_hold();
    apply_reset();
    res_ready = 1'b0;
    req_attr[0 +: AW]  = 24'hFFFFFF;
    req_coeff[0 +: AW] = 24'hFFFFFF;
    req_valid = 4'b0001;
    tick();
    wait_result();
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++;
      if (samp_rv !== 1'b1 || samp_acc !== 20'h2FA03 || samp_id !== 2'd0 || samp_ready !== '0) begin
        failures++;
        $display("FAIL hold cycle=%0d rv=%b acc=0x%05h id=%0d ready=%b required 1 0x2FA03 0 0000",
                 k, samp_rv, samp_acc, samp_id, samp_ready);
      end
    end
    res_ready = 1'b1;
    req_valid = '0;
    tick();
    #1;
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL hold_release rv=%b busy=%b required 0 0", res_valid, busy);
    end
    @(negedge clk);
    drain();
  endtask

  task automatic test_round_robin();
    apply_reset();
    res_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      req_attr[i*AW +: AW]  = AW'($urandom);
      req_coeff[i*AW +: AW] = AW'($urandom);
    end
    grant_log.delete();
    grant_time.delete();
    req_valid = 4'b1111;
    for (int k = 0; k < 60 && grant_log.size() < 6; k++) tick();
    req_valid = '0;
    checks++;
    if (grant_log.size() != 6) begin
      failures++;
      $display("FAIL rr_count grants=%0d required 6", grant_log.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (grant_log[k] != k % N) begin
          failures++;
          $display("FAIL rr_order slot=%0d granted=%0d required %0d", k, grant_log[k], k % N);
        end
      end
      for (int k = 1; k < 6; k++) begin
        checks++;
        if (grant_time[k] - grant_time[k-1] != 5) begin
          failures++;
          $display("FAIL rr_spacing slot=%0d cycles=%0d required 5", k, grant_time[k] - grant_time[k-1]);
        end
      end
    end
    drain();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    res_ready = 1'b1;
    req_attr[2*AW +: AW]  = 24'h112233;
    req_coeff[2*AW +: AW] = 24'h445566;
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    tick();
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0 || req_ready !== '0) begin
      failures++;
      $display("FAIL midreset busy=%b rv=%b ready=%b required 0 0 0000", busy, res_valid, req_ready);
    end
    @(negedge clk);
    tick();
    rst_n = 1'b1;
    grant_log.delete();
    req_attr[3*AW +: AW]  = 24'h030201;
    req_coeff[3*AW +: AW] = 24'h0A0B0C;
    req_attr[0 +: AW]     = 24'h7F8081;
    req_coeff[0 +: AW]    = 24'h020304;
    req_valid = 4'b1001;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL midreset_first ready=%b required 0001", req_ready);
    end
    tick();
    req_valid = 4'b1000;
    for (int k = 0; k < 20 && grant_log.size() < 2; k++) tick();
    req_valid = '0;
    checks++;
    if (grant_log.size() != 2 || grant_log[grant_log.size()-1] != 3) begin
      failures++;
      $display("FAIL midreset_second grants=%0d required 2 ending with id 3", grant_log.size());
    end
    drain();
  endtask

  task automatic test_operand_change();
    apply_reset();
    res_ready = 1'b1;
    req_attr[0 +: AW]  = 24'h0A0B0C;
    req_coeff[0 +: AW] = 24'h010101;
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    req_attr  = '0;
    req_coeff = '0;
    wait_result();
    checks++;
    if (samp_acc !== 20'd33 || samp_id !== 2'd0) begin
      failures++;
      $display("FAIL latched_ops acc=%0d id=%0d required 33 0", samp_acc, samp_id);
    end
    drain();
  endtask

  task automatic test_drop();
    apply_reset();
    res_ready = 1'b1;
    grant_log.delete();
    req_attr[0 +: AW]     = 24'h050607;
    req_coeff[0 +: AW]    = 24'h080900;
    req_attr[1*AW +: AW]  = 24'h111111;
    req_coeff[1*AW +: AW] = 24'h222222;
    req_valid = 4'b0001;
    tick();
    req_valid = 4'b0010;
    tick();
    checks++;
    if (samp_ready !== '0) begin
      failures++;
      $display("FAIL drop_busy_ready ready=%b required 0000", samp_ready);
    end
    req_valid = '0;
    drain();
    repeat (4) tick();
    checks++;
    if (grant_log.size() != 1 || grant_log[0] != 0) begin
      failures++;
      $display("FAIL drop_grants grants=%0d required 1 (id 0 only)", grant_log.size());
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    res_ready = 1'b0;
    req_attr  = '0;
    req_coeff = '0;
    test_reset();
    test_single();
    test_hold();
    test_round_robin();
    test_reset_mid();
    test_operand_change();
    test_drop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time=%0t required completion", $time);
    $fatal(1);
  end

endmodule

// File: doc/mac_rr_scheduler.md
Name: mac_rr_scheduler

Overview:
Shares one byte-serial 8x8 multiply-accumulate datapath between NUM_REQ requesters. Each requester presents a packed attribute/coefficient pair. The block grants requesters round-robin, latches the granted operands and sequences the lanes MSB-first through the multiplier/accumulator. It then returns the 20-bit dot product tagged with the requester id. It sits between the attribute/coefficient RAM readers and the downstream decision/compare stage.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ATTR_WIDTH, 24, attribute word width
RAM1_DATA_WIDTH, 24, coefficient word width (must equal ATTR_WIDTH)
LANE_WIDTH, 8, byte lane width
ACC_WIDTH, 20, accumulator/result width
NUM_LANES (localparam), ATTR_WIDTH/LANE_WIDTH = 3
ID_WIDTH (localparam), clog2(NUM_REQ)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester operand valid
req_ready  out  NUM_REQ  one-hot grant/accept; at most one bit high
req_attr  in  NUM_REQ*ATTR_WIDTH  packed attributes, requester i at [i*ATTR_WIDTH +: ATTR_WIDTH]
req_coeff  in  NUM_REQ*RAM1_DATA_WIDTH  packed coefficients, same packing
res_valid  out  1  result valid
res_ready  in  1  downstream accept
res_acc  out  ACC_WIDTH  dot-product result
res_id  out  ID_WIDTH  requester index of result
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async assert, sync release): state=IDLE, req_ready=0, res_valid=0, res_acc=0, res_id=0, busy=0, accumulator=0, lane counter=0, rr pointer=NUM_REQ-1, so requester 0 has top priority.
- States: IDLE, MAC, RESULT.
- IDLE: if any req_valid, req_ready[g]=1 combinationally in the same cycle. g is the first valid index searching upward from pointer+1, wrapping modulo NUM_REQ.
- At that edge: latch attr/coeff of g, id=g, pointer=g, accumulator=0, lane=0, go to MAC. No valid: stay in IDLE, no ready.
- MAC: one lane per cycle, lane 0 = bits [W-1:W-8], lane 2 = bits [7:0]. acc <= acc + a_lane*b_lane, with an unsigned 16-bit product zero-extended to ACC_WIDTH. After lane NUM_LANES-1, go to RESULT.
- Sums wrap modulo 2^ACC_WIDTH. The maximum 3*255*255 = 195075 never wraps at the defaults.
- req_ready=0 in MAC and RESULT. Input changes during MAC have no effect, because operands are latched.
- RESULT: res_valid=1, and res_acc/res_id are held stable until res_ready is sampled high. Then res_valid=0 at the next edge and the state returns to IDLE.
- res_ready high in RESULT's first cycle gives a 1-cycle RESULT.
- Latency: accept edge E0, lane edges E1..E3, res_valid visible after E3. Minimum 5 cycles per job accept-to-accept.
- Simultaneous valids: exactly one grant per IDLE cycle. Round-robin guarantees every persistently-valid requester is served within NUM_REQ jobs.
- req_valid may drop without handshake. A requester is only consumed on its req_ready&req_valid cycle.
- rst_n low mid-MAC or mid-RESULT: job discarded, outputs and state go to reset values immediately; no result is emitted.
- res_acc/res_id retain their last value after handshake; they are only meaningful with res_valid.

Decomposition:
- Shared package (mac_pkg): LANE_WIDTH, ACC_WIDTH, NUM_LANES constants and the state enum {IDLE, MAC, RESULT}.
- One natural sub-module: rr_arbiter (NUM_REQ request vector + pointer in, one-hot grant + encoded index out, purely combinational).
- The FSM, operand registers and accumulator stay in mac_rr_scheduler.

Test Plan:
- Req1 only, attr=0x010203, coeff=0x040506 -> req_ready[1] for 1 cycle; res_valid 4 edges later, res_acc=0x00020 (32), res_id=1.
- Req0, attr=coeff=0xFFFFFF -> res_acc=0x2FA03 (195075); res_ready held low 10 cycles -> res_valid/res_acc stable throughout, no new grant.
- All 4 valid continuously, res_ready=1 -> grant order 0,1,2,3,0,1; res_id sequence matches; 5 cycles per job.
- Req2 granted, then rst_n pulsed low at the 2nd MAC cycle -> res_valid never asserts, busy=0 immediately. After release with req3 and req0 valid, req0 is granted first.
- Req0 changes attr/coeff to 0 during MAC -> result still reflects the latched operands (e.g. 0x0A0B0C·0x010101 = 33).
- Req1 valid for 1 cycle while busy, then dropped -> never granted, no result for id 1.
